// File: rtl/bypass_controller.sv
// Decode/execute hazard scheduler: tracks EX/MEM destinations, registers operand
// bypass selections for the next EX instruction and inserts one bubble per load-use.
package bypass_controller_pkg;
    typedef enum logic [1:0] {
        BYPASS_NONE = 2'd0,
        BYPASS_EXEC = 2'd1,
        BYPASS_MEM  = 2'd2
    } bypass_ctrl_t;
endpackage

module bypass_controller
    import bypass_controller_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         idValid,
    input  logic [4:0]   idRs1Addr,
    input  logic [4:0]   idRs2Addr,
    input  logic         idRs1Used,
    input  logic         idRs2Used,
    input  logic [4:0]   idRdAddr,
    input  logic         idWrEnable,
    input  logic         idIsLoad,
    input  logic         flush,
    input  logic         memStall,
    output bypass_ctrl_t op1BypassCtrl,
    output bypass_ctrl_t op2BypassCtrl,
    output logic         stall,
    output logic [31:0]  stallCount
);

    logic         ex_valid_q, ex_wr_q, ex_load_q;
    logic [4:0]   ex_rd_q;
    logic         mem_valid_q, mem_wr_q;
    logic [4:0]   mem_rd_q;
    bypass_ctrl_t op1_q, op2_q;
    logic [31:0]  stall_count_q;

    logic         ex_valid_d, ex_wr_d, ex_load_d;
    logic [4:0]   ex_rd_d;
    logic         mem_valid_d, mem_wr_d;
    logic [4:0]   mem_rd_d;
    bypass_ctrl_t op1_d, op2_d;
    logic [31:0]  stall_count_d;

    logic src1_ex, src2_ex, src1_mem, src2_mem, load_use;
    bypass_ctrl_t op1_sel, op2_sel;

    // x0 never forwards, so a zero source address can never match
    assign src1_ex  = idValid && idRs1Used && ex_valid_q  && ex_wr_q  && (ex_rd_q  == idRs1Addr) && (idRs1Addr != 5'd0);
    assign src2_ex  = idValid && idRs2Used && ex_valid_q  && ex_wr_q  && (ex_rd_q  == idRs2Addr) && (idRs2Addr != 5'd0);
    assign src1_mem = idValid && idRs1Used && mem_valid_q && mem_wr_q && (mem_rd_q == idRs1Addr) && (idRs1Addr != 5'd0);
    assign src2_mem = idValid && idRs2Used && mem_valid_q && mem_wr_q && (mem_rd_q == idRs2Addr) && (idRs2Addr != 5'd0);

    assign op1_sel  = src1_ex ? BYPASS_EXEC : (src1_mem ? BYPASS_MEM : BYPASS_NONE);
    assign op2_sel  = src2_ex ? BYPASS_EXEC : (src2_mem ? BYPASS_MEM : BYPASS_NONE);

    assign load_use = (src1_ex || src2_ex) && ex_load_q;
    assign stall    = load_use && !flush;

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_rd_d       = ex_rd_q;
        ex_wr_d       = ex_wr_q;
        ex_load_d     = ex_load_q;
        mem_valid_d   = mem_valid_q;
        mem_rd_d      = mem_rd_q;
        mem_wr_d      = mem_wr_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        stall_count_d = stall_count_q;
        if (!memStall) begin
            mem_valid_d = ex_valid_q;
            mem_rd_d    = ex_rd_q;
            mem_wr_d    = ex_wr_q;
            if (flush || load_use) begin
                // bubble into EX; flush wins so a killed consumer never counts as a stall
                ex_valid_d = 1'b0;
                ex_rd_d    = 5'd0;
                ex_wr_d    = 1'b0;
                ex_load_d  = 1'b0;
                op1_d      = BYPASS_NONE;
                op2_d      = BYPASS_NONE;
                if (!flush) begin
                    stall_count_d = stall_count_q + 32'd1;
                end
            end else begin
                ex_valid_d = idValid;
                ex_rd_d    = idRdAddr;
                ex_wr_d    = idWrEnable;
                ex_load_d  = idIsLoad;
                op1_d      = op1_sel;
                op2_d      = op2_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid_q    <= 1'b0;
            ex_rd_q       <= 5'd0;
            ex_wr_q       <= 1'b0;
            ex_load_q     <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_rd_q      <= 5'd0;
            mem_wr_q      <= 1'b0;
            op1_q         <= BYPASS_NONE;
            op2_q         <= BYPASS_NONE;
            stall_count_q <= 32'd0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_rd_q       <= ex_rd_d;
            ex_wr_q       <= ex_wr_d;
            ex_load_q     <= ex_load_d;
            mem_valid_q   <= mem_valid_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            op1_q         <= op1_d;
            op2_q         <= op2_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign op1BypassCtrl = op1_q;
    assign op2BypassCtrl = op2_q;
    assign stallCount    = stall_count_q;

endmodule

// File: tb/tb_bypass_controller.sv
// Vector-table bench for bypass_controller: stall checked combinationally per row,
// registered ctrls/stallCount checked after the edge through a scoreboard queue.
module tb_bypass_controller;
    import bypass_controller_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         idValid, idRs1Used, idRs2Used, idWrEnable, idIsLoad, flush, memStall;
    logic [4:0]   idRs1Addr, idRs2Addr, idRdAddr;
    bypass_ctrl_t op1BypassCtrl, op2BypassCtrl;
    logic         stall;
    logic [31:0]  stallCount;

    int pass_cnt  = 0;
    int check_cnt = 0;

    typedef struct {
        logic         rst_n, v;
        logic [4:0]   rs1;
        logic         u1;
        logic [4:0]   rs2;
        logic         u2;
        logic [4:0]   rd;
        logic         wr, ld, fl, ms;
        logic         e_stall;
        bypass_ctrl_t e1, e2;
        logic [31:0]  ecnt;
    } vec_t;

    typedef struct {
        bypass_ctrl_t e1, e2;
        logic [31:0]  ecnt;
        int           idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    localparam bypass_ctrl_t N = BYPASS_NONE;
    localparam bypass_ctrl_t E = BYPASS_EXEC;
    localparam bypass_ctrl_t M = BYPASS_MEM;

    bypass_controller dut (
        .clk(clk), .rst(rst),
        .idValid(idValid), .idRs1Addr(idRs1Addr), .idRs2Addr(idRs2Addr),
        .idRs1Used(idRs1Used), .idRs2Used(idRs2Used), .idRdAddr(idRdAddr),
        .idWrEnable(idWrEnable), .idIsLoad(idIsLoad), .flush(flush), .memStall(memStall),
        .op1BypassCtrl(op1BypassCtrl), .op2BypassCtrl(op2BypassCtrl),
        .stall(stall), .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic rst_n, logic v, logic [4:0] rs1, logic u1,
                                logic [4:0] rs2, logic u2, logic [4:0] rd, logic wr,
                                logic ld, logic fl, logic ms, logic e_stall,
                                bypass_ctrl_t e1, bypass_ctrl_t e2, logic [31:0] ecnt);
        vec_t r;
        r.rst_n = rst_n; r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
        r.rd = rd; r.wr = wr; r.ld = ld; r.fl = fl; r.ms = ms;
        r.e_stall = e_stall; r.e1 = e1; r.e2 = e2; r.ecnt = ecnt;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        check_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s row %0d: got %0d required %0d", name, idx, act, req);
    endtask

    task automatic apply(input vec_t vv, input int idx);
        exp_t e;
        @(negedge clk);
        rst = vv.rst_n; idValid = vv.v;
        idRs1Addr = vv.rs1; idRs1Used = vv.u1; idRs2Addr = vv.rs2; idRs2Used = vv.u2;
        idRdAddr = vv.rd; idWrEnable = vv.wr; idIsLoad = vv.ld;
        flush = vv.fl; memStall = vv.ms;
        #1;
        check("stall", idx, {31'd0, stall}, {31'd0, vv.e_stall});
        e.e1 = vv.e1; e.e2 = vv.e2; e.ecnt = vv.ecnt; e.idx = idx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_cnt++;
            $display("FAIL scoreboard row %0d: got empty queue required one entry", idx);
        end else begin
            e = sb.pop_front();
            check("op1", e.idx, {30'd0, op1BypassCtrl}, {30'd0, e.e1});
            check("op2", e.idx, {30'd0, op2BypassCtrl}, {30'd0, e.e2});
            check("stallCount", e.idx, stallCount, e.ecnt);
        end
    endtask

    initial begin
        rst = 1'b0; idValid = 1'b0; idRs1Addr = '0; idRs2Addr = '0; idRs1Used = 1'b0;
        idRs2Used = 1'b0; idRdAddr = '0; idWrEnable = 1'b0; idIsLoad = 1'b0;
        flush = 1'b0; memStall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_op1", -1, {30'd0, op1BypassCtrl}, {30'd0, BYPASS_NONE});
        check("reset_op2", -1, {30'd0, op2BypassCtrl}, {30'd0, BYPASS_NONE});
        check("reset_cnt", -1, stallCount, 32'd0);
        check("reset_stall", -1, {31'd0, stall}, 32'd0);

        //              rst v  rs1 u1 rs2 u2 rd wr ld fl ms  st op1 op2 cnt
        vecs.push_back(mk(1, 1,  0, 0,  0, 0,  5, 1, 0, 0, 0, 0, N, N, 0)); // add x5
        vecs.push_back(mk(1, 1,  5, 1,  6, 1,  8, 1, 0, 0, 0, 0, E, N, 0)); // sub rs1=x5
        vecs.push_back(mk(1, 1,  1, 1,  5, 1,  9, 1, 0, 0, 0, 0, N, M, 0)); // two behind
        vecs.push_back(mk(1, 1,  1, 1,  0, 0,  7, 1, 1, 0, 0, 0, N, N, 0)); // lw x7
        vecs.push_back(mk(1, 1,  2, 1,  7, 1, 10, 1, 0, 0, 0, 1, N, N, 1)); // load-use
        vecs.push_back(mk(1, 1,  2, 1,  7, 1, 10, 1, 0, 0, 0, 0, N, M, 1)); // held, MEM
        vecs.push_back(mk(1, 1,  0, 0,  0, 0,  0, 1, 0, 0, 0, 0, N, N, 1)); // rd=x0
        vecs.push_back(mk(1, 1,  0, 1,  0, 1,  3, 1, 0, 0, 0, 0, N, N, 1)); // reads x0
        vecs.push_back(mk(1, 1,  3, 0,  0, 0,  4, 1, 0, 0, 0, 0, N, N, 1)); // x3 unused
        vecs.push_back(mk(1, 1,  3, 1,  0, 0,  4, 1, 0, 0, 0, 0, M, N, 1)); // add x4 again
        vecs.push_back(mk(1, 1,  4, 1,  4, 1, 11, 1, 0, 0, 0, 0, E, E, 1)); // youngest wins
        vecs.push_back(mk(1, 1,  0, 0,  0, 0,  2, 1, 1, 0, 0, 0, N, N, 1)); // lw x2
        vecs.push_back(mk(1, 1,  2, 1,  0, 0, 12, 1, 0, 1, 0, 0, N, N, 1)); // flush
        vecs.push_back(mk(1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, N, N, 1));
        vecs.push_back(mk(1, 1,  0, 0,  0, 0, 13, 1, 0, 0, 0, 0, N, N, 1));
        vecs.push_back(mk(1, 1, 13, 1,  0, 0, 14, 1, 0, 0, 0, 0, E, N, 1));
        vecs.push_back(mk(1, 1, 14, 1, 13, 1, 15, 1, 0, 0, 1, 0, E, N, 1)); // freeze x3
        vecs.push_back(mk(1, 1, 14, 1, 13, 1, 15, 1, 0, 0, 1, 0, E, N, 1));
        vecs.push_back(mk(1, 1, 14, 1, 13, 1, 15, 1, 0, 0, 1, 0, E, N, 1));
        vecs.push_back(mk(1, 1, 14, 1, 13, 1, 15, 1, 0, 0, 0, 0, E, M, 1));
        vecs.push_back(mk(1, 1,  0, 0,  0, 0, 16, 1, 1, 0, 0, 0, N, N, 1)); // lw x16
        vecs.push_back(mk(1, 1, 16, 1,  0, 0, 17, 1, 0, 0, 1, 1, N, N, 1)); // stall under freeze
        vecs.push_back(mk(1, 1, 16, 1,  0, 0, 17, 1, 0, 0, 0, 1, N, N, 2));
        vecs.push_back(mk(1, 1, 16, 1,  0, 0, 17, 1, 0, 0, 0, 0, M, N, 2));
        vecs.push_back(mk(1, 1,  0, 0,  0, 0, 18, 1, 1, 0, 0, 0, N, N, 2)); // lw x18
        vecs.push_back(mk(0, 1,  0, 0, 18, 1, 19, 1, 0, 0, 0, 1, N, N, 0)); // reset mid-stall
        vecs.push_back(mk(1, 1,  0, 0, 18, 1, 19, 1, 0, 0, 0, 0, N, N, 0));
        vecs.push_back(mk(1, 1, 19, 1,  0, 0, 20, 1, 0, 0, 0, 0, E, N, 0));

        foreach (vecs[i]) apply(vecs[i], i);

        // repeated load-use hazards: one stall and one count per hazard
        for (int k = 0; k < 3; k++) begin
            apply(mk(1, 1, 0, 0, 0, 0, 5'(21 + k), 1, 1, 0, 0, 0, N, N, 32'(k)), 100 + 3 * k);
            apply(mk(1, 1, 5'(21 + k), 1, 0, 0, 0, 0, 0, 0, 0, 1, N, N, 32'(k + 1)), 101 + 3 * k);
            apply(mk(1, 1, 5'(21 + k), 1, 0, 0, 0, 0, 0, 0, 0, 0, M, N, 32'(k + 1)), 102 + 3 * k);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
